// File: rtl/rvfi_mon_pkg.sv
// Shared record type and order-tracker state encoding for the RVFI retirement monitor.
package rvfi_mon_pkg;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
    } rvfi_rec_t;

    localparam int REC_W = $bits(rvfi_rec_t);

    typedef enum logic [0:0] {
        ORD_IDLE  = 1'b0,
        ORD_TRACK = 1'b1
    } ord_state_e;

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Small record FIFO; a push into a full FIFO is still accepted when the head pops the same cycle.
module rvfi_rec_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         data_i,
    output logic                     push_acc_o,
    input  logic                     ready_i,
    output logic                     valid_o,
    output T                         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    assign valid_o    = (count_o != '0);
    assign pop        = valid_o && ready_i;
    assign push_acc_o = push_i && ((count_o < CW'(DEPTH)) || pop);
    // Gate the head so the record port reads zero while empty.
    assign data_o     = valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push_acc_o) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_acc_o) wr_ptr <= wr_ptr + 1'b1;
            if (pop)        rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc_o, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_retire_buffer.sv
// Captures RVFI retirements into a FIFO for downstream checkers and flags protocol faults.
module rvfi_retire_buffer
    import rvfi_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rvfi_valid_i,
    input  logic [63:0]              rvfi_order_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic [4:0]               rvfi_rs1_addr_i,
    input  logic [31:0]              rvfi_rs1_rdata_i,
    input  logic [4:0]               rvfi_rs2_addr_i,
    input  logic [31:0]              rvfi_rs2_rdata_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [REC_W-1:0]         rec_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         retired_cnt_o,
    output logic                     overflow_o,
    output logic                     order_err_o,
    output logic                     x0_err_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    rvfi_rec_t  in_rec;
    rvfi_rec_t  head_rec;
    logic       push_acc;
    ord_state_e ord_state;
    logic [63:0] last_order;

    assign in_rec = '{
        rd_addr:   rvfi_rd_addr_i,
        rd_wdata:  rvfi_rd_wdata_i,
        rs1_addr:  rvfi_rs1_addr_i,
        rs1_rdata: rvfi_rs1_rdata_i,
        rs2_addr:  rvfi_rs2_addr_i,
        rs2_rdata: rvfi_rs2_rdata_i
    };

    rvfi_rec_fifo #(.DEPTH(DEPTH), .T(rvfi_rec_t)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (rvfi_valid_i),
        .data_i     (in_rec),
        .push_acc_o (push_acc),
        .ready_i    (rec_ready_i),
        .valid_o    (rec_valid_o),
        .data_o     (head_rec),
        .count_o    (count_o)
    );

    assign rec_o = head_rec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_cnt_o <= '0;
            overflow_o    <= 1'b0;
            x0_err_o      <= 1'b0;
        end else if (rvfi_valid_i) begin
            if (push_acc && retired_cnt_o != '1) retired_cnt_o <= retired_cnt_o + 1'b1;
            if (!push_acc)                       overflow_o    <= 1'b1;
            if (rvfi_rd_addr_i == '0 && rvfi_rd_wdata_i != '0) x0_err_o <= 1'b1;
        end
    end

    // Dropped retirements still advance the order tracker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ord_state   <= ORD_IDLE;
            last_order  <= '0;
            order_err_o <= 1'b0;
        end else if (rvfi_valid_i) begin
            last_order <= rvfi_order_i;
            case (ord_state)
                ORD_IDLE:  ord_state <= ORD_TRACK;
                ORD_TRACK: if (rvfi_order_i != last_order + 64'd1) order_err_o <= 1'b1;
                default:   ord_state <= ORD_IDLE;
            endcase
        end
    end

    a_rec_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rec_valid_o && !rec_ready_i) |=> (!rec_valid_o || $stable(rec_o)));
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count_o <= CW'(DEPTH));

endmodule
